// File: rtl/host_cmd_parser.sv
// Byte-stream host command parser: 5-byte writes and 3-byte reads onto the local register bus.
// Optional HOST_CMD_ERR_EN: answer an unknown opcode with ERR_BYTE on the TX FIFO.
module host_cmd_parser #(
    parameter logic [7:0] OP_WRITE = 8'h01,
    parameter logic [7:0] OP_READ  = 8'h00
`ifdef HOST_CMD_ERR_EN
    ,
    parameter logic [7:0] ERR_BYTE = 8'hEE
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_rd,
    input  logic        rx_emp,
    output logic        rx_re,
    output logic [7:0]  tx_wd,
    output logic        tx_we,
    input  logic        tx_ful,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    output logic        bus_wr,
    output logic        bus_rd,
    input  logic [15:0] bus_rdata,
    output logic        busy
);
    // state           | meaning
    // S_OP/AH/AL/DH/DL | fetch opcode, addr hi/lo, wdata hi/lo
    // S_WR/S_RD/S_RL   | write strobe, read strobe, latch bus_rdata
    // S_TH/S_TL/S_ERR  | push read data hi/lo, unknown opcode
    typedef enum logic [3:0] {
        S_OP, S_AH, S_AL, S_DH, S_DL, S_WR, S_RD, S_RL, S_TH, S_TL, S_ERR
    } state_t;

    state_t      state;
    logic        pend;
    logic        wr_cmd;
    logic [15:0] rbuf;
    logic        fetch_st;
    logic        cap;

    assign fetch_st = (state == S_OP) || (state == S_AH) || (state == S_AL) ||
                      (state == S_DH) || (state == S_DL);
    assign cap      = pend && !rx_re;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_OP;
            pend      <= 1'b0;
            wr_cmd    <= 1'b0;
            rbuf      <= 16'h0000;
            rx_re     <= 1'b0;
            tx_we     <= 1'b0;
            tx_wd     <= 8'h00;
            bus_addr  <= 16'h0000;
            bus_wdata <= 16'h0000;
            bus_wr    <= 1'b0;
            bus_rd    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            bus_wr <= 1'b0;
            bus_rd <= 1'b0;
            if (fetch_st) begin
                if (rx_re) begin
                    rx_re <= 1'b0;
                end else if (pend) begin
                    pend <= 1'b0;
                end else if (!rx_emp) begin
                    rx_re <= 1'b1;
                    pend  <= 1'b1;
                end
            end
            // A capture that lands in another fetch state launches the next read at once.
            case (state)
                S_OP: if (cap) begin
                    busy <= 1'b1;
                    if (rx_rd == OP_WRITE || rx_rd == OP_READ) begin
                        wr_cmd <= (rx_rd == OP_WRITE);
                        state  <= S_AH;
                        rx_re  <= !rx_emp;
                        pend   <= !rx_emp;
                    end else begin
                        state <= S_ERR;
                    end
                end
                S_AH: if (cap) begin
                    bus_addr[15:8] <= rx_rd;
                    state          <= S_AL;
                    rx_re          <= !rx_emp;
                    pend           <= !rx_emp;
                end
                S_AL: if (cap) begin
                    bus_addr[7:0] <= rx_rd;
                    if (wr_cmd) begin
                        state <= S_DH;
                        rx_re <= !rx_emp;
                        pend  <= !rx_emp;
                    end else begin
                        state  <= S_RD;
                        bus_rd <= 1'b1;
                    end
                end
                S_DH: if (cap) begin
                    bus_wdata[15:8] <= rx_rd;
                    state           <= S_DL;
                    rx_re           <= !rx_emp;
                    pend            <= !rx_emp;
                end
                S_DL: if (cap) begin
                    bus_wdata[7:0] <= rx_rd;
                    state          <= S_WR;
                    bus_wr         <= 1'b1;
                end
                S_WR: begin
                    state <= S_OP;
                    busy  <= 1'b0;
                    rx_re <= !rx_emp;
                    pend  <= !rx_emp;
                end
                S_RD: state <= S_RL;
                // tx_we is registered, so tx_ful is judged one cycle before the strobe it gates.
                S_RL: begin
                    rbuf  <= bus_rdata;
                    state <= S_TH;
                    if (!tx_ful) begin
                        tx_we <= 1'b1;
                        tx_wd <= bus_rdata[15:8];
                    end
                end
                S_TH: begin
                    if (tx_we) begin
                        state <= S_TL;
                        tx_we <= !tx_ful;
                        if (!tx_ful) tx_wd <= rbuf[7:0];
                    end else if (!tx_ful) begin
                        tx_we <= 1'b1;
                        tx_wd <= rbuf[15:8];
                    end
                end
                S_TL: begin
                    if (tx_we) begin
                        tx_we <= 1'b0;
                        state <= S_OP;
                        busy  <= 1'b0;
                        rx_re <= !rx_emp;
                        pend  <= !rx_emp;
                    end else if (!tx_ful) begin
                        tx_we <= 1'b1;
                        tx_wd <= rbuf[7:0];
                    end
                end
                S_ERR: begin
`ifdef HOST_CMD_ERR_EN
                    if (tx_we) begin
                        tx_we <= 1'b0;
                        state <= S_OP;
                        busy  <= 1'b0;
                        rx_re <= !rx_emp;
                        pend  <= !rx_emp;
                    end else if (!tx_ful) begin
                        tx_we <= 1'b1;
                        tx_wd <= ERR_BYTE;
                    end
`else
                    state <= S_OP;
                    busy  <= 1'b0;
                    rx_re <= !rx_emp;
                    pend  <= !rx_emp;
`endif
                end
                default: begin
                    state <= S_OP;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_host_cmd_parser.sv
// Bench for host_cmd_parser: RX FIFO model, bus read-data model, scoreboard of bus/TX events.
// Expectations follow HOST_CMD_ERR_EN when it is defined for the build.
module tb_host_cmd_parser;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_rd = 8'h00;
    logic        rx_emp = 1'b1;
    logic        rx_re;
    logic [7:0]  tx_wd;
    logic        tx_we;
    logic        tx_ful;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_wr;
    logic        bus_rd;
    logic [15:0] bus_rdata = 16'h0BAD;
    logic        busy;

`ifdef HOST_CMD_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    host_cmd_parser dut (
        .clk(clk), .rst(rst), .rx_rd(rx_rd), .rx_emp(rx_emp), .rx_re(rx_re),
        .tx_wd(tx_wd), .tx_we(tx_we), .tx_ful(tx_ful), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wr(bus_wr), .bus_rd(bus_rd),
        .bus_rdata(bus_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RX FIFO model: registered empty flag, data valid the cycle after rx_re
    logic [7:0] rx_mem [256];
    int   wp = 0;
    int   rp = 0;
    logic uf = 1'b0;
    always @(posedge clk) begin
        if (rx_re) begin
            if (rp == wp) uf <= 1'b1;
            else begin
                rx_rd <= rx_mem[rp];
                rp    <= rp + 1;
            end
        end
        rx_emp <= (((rx_re && rp != wp) ? rp + 1 : rp) == wp);
    end

    // read data is only valid the single cycle after bus_rd
    logic [15:0] rd_val = 16'h0000;
    always @(posedge clk) bus_rdata <= bus_rd ? rd_val : 16'h0BAD;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;
    ev_t sb[$];

    typedef struct {
        logic [7:0]  b [8];
        int          n;
        int          op;
        logic        err;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] rdata;
        logic        tchk;
    } vec_t;
    vec_t vt [8];

    int checks = 0;
    int errors = 0;
    int t_wr = -1, t_rd = -1, tx_prev = -1, tx_last = -1;
    logic [15:0] m_addr = 16'h0000, m_wdata = 16'h0000;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic sb_check(input int kind, input logic [15:0] addr, input logic [15:0] data);
        ev_t e;
        chk("event_expected", {32'h0, sb.size() != 0}, 64'h1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("event", {kind[7:0], addr, data}, {e.kind[7:0], e.addr, e.data});
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus_wr) begin
                    t_wr = cyc;
                    sb_check(0, bus_addr, bus_wdata);
                end
                if (bus_rd) begin
                    t_rd = cyc;
                    sb_check(1, bus_addr, 16'h0000);
                end
                if (tx_we) begin
                    tx_prev = tx_last;
                    tx_last = cyc;
                    chk("tx_we_while_full", tx_ful, 0);
                    sb_check(2, 16'h0000, {8'h00, tx_wd});
                end
            end
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_mem[wp] = b;
        wp = wp + 1;
    endtask

    task automatic expect_wr(input logic [15:0] a, input logic [15:0] d);
        sb.push_back('{0, a, d});
        m_addr  = a;
        m_wdata = d;
    endtask

    task automatic expect_rd(input logic [15:0] a, input logic [15:0] rd);
        sb.push_back('{1, a, 16'h0000});
        sb.push_back('{2, 16'h0000, {8'h00, rd[15:8]}});
        sb.push_back('{2, 16'h0000, {8'h00, rd[7:0]}});
        m_addr = a;
        rd_val = rd;
    endtask

    task automatic wait_rx_re(input string name, output int t);
        int n = 0;
        while (!rx_re && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, rx_re, 1);
        t = cyc;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(sb.size() == 0 && rp == wp && !busy && !rx_re) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, {32'h0, n < 400}, 64'h1);
        repeat (3) @(negedge clk);
        chk("addr_hold", bus_addr, m_addr);
        chk("wdata_hold", bus_wdata, m_wdata);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        int cnt_re, cnt_we, busy_low, n;
        vt[0] = '{'{8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00}, 5, 0, 1'b0, 16'h1234, 16'hABCD, 16'h0000, 1'b1};
        vt[1] = '{'{8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 1, 1'b0, 16'h000C, 16'h0000, 16'hBEEF, 1'b1};
        vt[2] = '{'{8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5, 0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
        vt[3] = '{'{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 1, 1'b0, 16'hFFFF, 16'h0000, 16'h0001, 1'b1};
        vt[4] = '{'{8'h5A, 8'h01, 8'h00, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00}, 6, 0, 1'b1, 16'h0010, 16'h0001, 16'h0000, 1'b0};
        vt[5] = '{'{8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 1, 1'b0, 16'h1234, 16'h0000, 16'h8001, 1'b1};
        vt[6] = '{'{8'hFF, 8'h00, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 1, 1'b1, 16'hABCD, 16'h0000, 16'h5AA5, 1'b0};
        vt[7] = '{'{8'h02, 8'h01, 8'h00, 8'h00, 8'h77, 8'h88, 8'h00, 8'h00}, 6, 0, 1'b1, 16'h0000, 16'h7788, 16'h0000, 1'b0};

        rst = 1'b1;
        tx_ful = 1'b0;
        fork monitor(); join_none
        repeat (3) @(negedge clk);
        chk("reset_outputs", {rx_re, tx_we, bus_wr, bus_rd, busy, tx_wd, bus_addr, bus_wdata}, 64'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            if (vt[i].err && ERR_EN) sb.push_back('{2, 16'h0000, 16'h00EE});
            if (vt[i].op == 0) expect_wr(vt[i].addr, vt[i].data);
            else expect_rd(vt[i].addr, vt[i].rdata);
            for (int k = 0; k < vt[i].n; k++) push_byte(vt[i].b[k]);
            wait_rx_re($sformatf("v%0d_rx_re_seen", i), t0);
            wait_done($sformatf("v%0d_done", i));
            if (vt[i].tchk && vt[i].op == 0)
                chk($sformatf("v%0d_wr_latency", i), t_wr - t0, 10);
            if (vt[i].tchk && vt[i].op == 1) begin
                chk($sformatf("v%0d_rd_latency", i), t_rd - t0, 6);
                chk($sformatf("v%0d_tx_hi_latency", i), tx_prev - t0, 8);
                chk($sformatf("v%0d_tx_lo_latency", i), tx_last - t0, 9);
            end
        end

        // 15 idle cycles with the RX FIFO empty in the middle of a write
        expect_wr(16'h1234, 16'hABCD);
        push_byte(8'h01);
        push_byte(8'h12);
        n = 0;
        while (rp != wp && n < 50) begin
            @(negedge clk);
            n++;
        end
        busy_low = 0;
        repeat (15) begin
            @(negedge clk);
            if (!busy) busy_low++;
        end
        chk("gap_busy_low_cycles", busy_low, 0);
        push_byte(8'h34);
        push_byte(8'hAB);
        push_byte(8'hCD);
        wait_done("gap_done");

        // TX full across a read, with the next command already waiting in RX
        tx_ful = 1'b1;
        expect_rd(16'h000C, 16'hBEEF);
        push_byte(8'h00);
        push_byte(8'h00);
        push_byte(8'h0C);
        n = 0;
        while (!bus_rd && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_rd_seen", bus_rd, 1);
        sb.push_back('{0, 16'h0020, 16'h1234});
        push_byte(8'h01);
        push_byte(8'h00);
        push_byte(8'h20);
        push_byte(8'h12);
        push_byte(8'h34);
        cnt_re = 0;
        cnt_we = 0;
        repeat (20) begin
            @(negedge clk);
            if (rx_re) cnt_re++;
            if (tx_we) cnt_we++;
        end
        chk("stall_rx_re_count", cnt_re, 0);
        chk("stall_tx_we_count", cnt_we, 0);
        tx_ful = 1'b0;
        m_addr = 16'h0020;
        m_wdata = 16'h1234;
        wait_done("stall_done");

        // reset in the middle of a write discards it
        push_byte(8'h01);
        push_byte(8'h12);
        push_byte(8'h34);
        n = 0;
        while (rp != wp && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midcmd_reset_outputs", {rx_re, tx_we, bus_wr, bus_rd, busy, tx_wd, bus_addr, bus_wdata}, 64'h0);
        @(negedge clk);
        chk("midcmd_reset_hold", {rx_re, tx_we, bus_wr, bus_rd, busy, tx_wd, bus_addr, bus_wdata}, 64'h0);
        rst = 1'b0;
        m_wdata = 16'h0000;
        expect_rd(16'h0001, 16'hC3A5);
        @(negedge clk);
        push_byte(8'h00);
        push_byte(8'h00);
        push_byte(8'h01);
        wait_done("post_reset_done");

        repeat (5) @(negedge clk);
        chk("rx_underflow", uf, 0);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
